// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
// Request/result bundle between the execute stage and the multiply/divide unit.
//   master : execute stage - drives start, alucontrol, a, b, flush;
//            observes busy, done, hi, lo
//   slave  : muldiv_unit   - the reverse
// Parameters: WIDTH (operand and HI/LO width), CTRL_W (alucontrol width).
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 5
);
    logic              start;
    logic [CTRL_W-1:0] alucontrol;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    modport master (
        output start, alucontrol, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, alucontrol, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : muldiv_unit_if.slave
//          start/alucontrol/a/b request (accepted only when idle), flush abort,
//          busy stall, done one-cycle commit pulse, hi/lo registers.
// Divide is restoring radix-2 over WIDTH cycles plus one sign-fix cycle.
// Optional macro MULDIV_ITER_MULT_EN: multiply becomes a WIDTH-cycle shift-add
// on magnitudes followed by the same sign-fix cycle; otherwise it is a
// single-cycle full-width product.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int                WIDTH             = 32,
    parameter int                CTRL_W            = 5,
    parameter logic [CTRL_W-1:0] ALU_SIGNED_MULT   = 5'h0C,
    parameter logic [CTRL_W-1:0] ALU_UNSIGNED_MULT = 5'h0D,
    parameter logic [CTRL_W-1:0] ALU_SIGNED_DIV    = 5'h0E,
    parameter logic [CTRL_W-1:0] ALU_UNSIGNED_DIV  = 5'h0F,
    parameter logic [CTRL_W-1:0] ALU_MTHI          = 5'h10,
    parameter logic [CTRL_W-1:0] ALU_MTLO          = 5'h11
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [WIDTH-1:0]    hi_q;
    logic [WIDTH-1:0]    lo_q;
    logic [WIDTH-1:0]    a_q;        // raw dividend, returned as HI on divide-by-zero
    logic [WIDTH-1:0]    mag_q;      // divisor magnitude / multiplicand magnitude
    logic [2*WIDTH-1:0]  acc_q;      // {remainder, quotient} or {product hi, multiplier/product lo}
    logic [CNT_W-1:0]    cnt_q;
    logic                is_div_q;
    logic                neg_q;      // result (quotient or product) needs negation
    logic                a_neg_q;    // remainder takes the dividend's sign
    logic                b_zero_q;

    logic [WIDTH:0]      div_shift_s;
    logic [WIDTH:0]      div_diff_s;
    logic [2*WIDTH-1:0]  div_next_s;
    logic                req_signed_s;

    // Magnitude of a value that is signed only when sgn is set.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

`ifdef MULDIV_ITER_MULT_EN
    logic [WIDTH:0]      mul_sum_s;
    logic [2*WIDTH-1:0]  mul_next_s;
    logic [2*WIDTH-1:0]  mul_fix_s;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};
        if (neg_q) begin
            mul_fix_s = -acc_q;
        end else begin
            mul_fix_s = acc_q;
        end
    end
`else
    logic [WIDTH-1:0]    b_q;
    logic [2*WIDTH-1:0]  ext_a_s;
    logic [2*WIDTH-1:0]  ext_b_s;
    logic [2*WIDTH-1:0]  prod_s;

    // Single-cycle product: extending both operands to 2*WIDTH (sign or zero)
    // makes the low 2*WIDTH bits of one unsigned multiply correct for both ops.
    always_comb begin
        if (neg_q) begin
            ext_a_s = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            ext_b_s = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end else begin
            ext_a_s = {{WIDTH{1'b0}}, a_q};
            ext_b_s = {{WIDTH{1'b0}}, b_q};
        end
        prod_s = ext_a_s * ext_b_s;
    end
`endif

    // Restoring divide step: shift next dividend bit into the partial
    // remainder and keep the difference only if it did not go negative.
    always_comb begin
        div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff_s  = div_shift_s - {1'b0, mag_q};
        if (!div_diff_s[WIDTH]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        req_signed_s = (bus.alucontrol == ALU_SIGNED_MULT) || (bus.alucontrol == ALU_SIGNED_DIV);
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
`ifndef MULDIV_ITER_MULT_EN
            b_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            case (bus.alucontrol)
                                ALU_SIGNED_MULT, ALU_UNSIGNED_MULT: begin
                                    a_q      <= bus.a;
`ifndef MULDIV_ITER_MULT_EN
                                    b_q      <= bus.b;
                                    // single-cycle path reuses neg_q as the signed flag
                                    neg_q    <= req_signed_s;
`else
                                    neg_q    <= req_signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`endif
                                    mag_q    <= magnitude(bus.a, req_signed_s);
                                    acc_q    <= {{WIDTH{1'b0}}, magnitude(bus.b, req_signed_s)};
                                    cnt_q    <= '0;
                                    is_div_q <= 1'b0;
                                    state_q  <= S_MUL;
                                    busy_q   <= 1'b1;
                                end
                                ALU_SIGNED_DIV, ALU_UNSIGNED_DIV: begin
                                    a_q      <= bus.a;
                                    mag_q    <= magnitude(bus.b, req_signed_s);
                                    acc_q    <= {{WIDTH{1'b0}}, magnitude(bus.a, req_signed_s)};
                                    neg_q    <= req_signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                                    a_neg_q  <= req_signed_s & bus.a[WIDTH-1];
                                    b_zero_q <= (bus.b == '0);
                                    cnt_q    <= '0;
                                    is_div_q <= 1'b1;
                                    state_q  <= S_DIV;
                                    busy_q   <= 1'b1;
                                end
                                ALU_MTHI: begin
                                    hi_q   <= bus.a;
                                    done_q <= 1'b1;
                                end
                                ALU_MTLO: begin
                                    lo_q   <= bus.a;
                                    done_q <= 1'b1;
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                end
                            endcase
                        end
                    end
                    S_MUL: begin
`ifdef MULDIV_ITER_MULT_EN
                        acc_q <= mul_next_s;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_FIX;
                        end
`else
                        hi_q    <= prod_s[2*WIDTH-1:WIDTH];
                        lo_q    <= prod_s[WIDTH-1:0];
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                    S_DIV: begin
                        acc_q <= div_next_s;
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        if (is_div_q) begin
                            if (b_zero_q) begin
                                // divide by zero: defined result instead of a trap
                                lo_q <= '1;
                                hi_q <= a_q;
                            end else begin
                                lo_q <= neg_q   ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                                hi_q <= a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                            end
                        end else begin
`ifdef MULDIV_ITER_MULT_EN
                            hi_q <= mul_fix_s[2*WIDTH-1:WIDTH];
                            lo_q <= mul_fix_s[WIDTH-1:0];
`else
                            hi_q <= hi_q;
                            lo_q <= lo_q;
`endif
                        end
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It takes the decoded `alucontrol` code for MULT/MULTU/DIV/DIVU/MTHI/MTLO plus two operands. Divides, and optionally multiplies, run iteratively while `busy` stalls the pipeline. A one-cycle `done` pulse marks each HI/LO commit.

## Interface
- `WIDTH`, 32, operand and HI/LO width; 8 ≤ WIDTH ≤ 64.
- `CTRL_W`, 5, width of `alucontrol`. Codes come from `aludefines.vh`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid; accepted only in IDLE.
- `alucontrol`  in  CTRL_W  one of `ALU_SIGNED_MULT`, `ALU_UNSIGNED_MULT`, `ALU_SIGNED_DIV`, `ALU_UNSIGNED_DIV`, `ALU_MTHI`, `ALU_MTLO`.
- `a`  in  WIDTH  rs operand: dividend / multiplicand / MT source.
- `b`  in  WIDTH  rt operand: divisor / multiplier.
- `flush`  in  1  abort the in-flight operation (exception/branch flush).
- `busy`  out  1  high while state ≠ IDLE; the pipeline stalls on it.
- `done`  out  1  registered one-cycle pulse in the cycle HI/LO change.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, flush=0:
  - Latch `a`, `b` and the op.
  - MULT/MULTU → MUL.
  - DIV/DIVU → DIV; load |a|, |b| (magnitudes for signed, raw for unsigned); iteration counter = 0.
  - MTHI/MTLO → write hi/lo from `a` at this edge, set done; stay IDLE.
  - Any other code → ignored, no state change.
- `start` while `busy` is ignored. The stage holds its request under stall.
- MUL:
  - Without macro: one cycle. The full 2·WIDTH product (signed or unsigned) is written at the edge: hi = upper half, lo = lower half. done=1, → IDLE.
  - With macro: see Configuration.
- DIV: restoring radix-2, one quotient bit per cycle, WIDTH cycles. When counter reaches WIDTH-1 → FIX.
- FIX:
  - Signed only: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
  - Write lo = quotient, hi = remainder. done=1, → IDLE.
- Divide by zero: no trap, same latency. lo = all ones, hi = original `a`, for both signed and unsigned.
- Signed MIN / −1: lo = MIN, hi = 0, from natural wrap.
- `flush` (any state): → IDLE at the edge. hi/lo unchanged, done=0. If flush and start are high in the same cycle, flush wins and nothing is accepted.
- `rst`: state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation discards the result.

## Timing
- Accept edge E0; busy rises after E0.
- Multiply (single-cycle): hi/lo and done visible after E1; busy high 1 cycle.
- Divide: WIDTH iteration edges E1..E_WIDTH, FIX at E_WIDTH+1. Result and done visible after E_WIDTH+1; busy high exactly WIDTH+1 cycles.
- MTHI/MTLO: hi/lo and done visible after E0; busy never asserts.
- `done` drops the following cycle. A new start is acceptable in the cycle done is high (busy=0 then).
- Outputs are registered only; no combinational path from `a`/`b` to `hi`/`lo`.

## Configuration
- `MULDIV_ITER_MULT_EN` defined:
  - MUL is a shift-add iteration over WIDTH cycles on magnitudes, with a FIX cycle that negates the 2·WIDTH product iff the signs differ (signed only).
  - Multiply latency = WIDTH+1, same as divide; no hardware multiplier inferred.
- Undefined: single-cycle `*` multiply as described above.
- Divide, MT, flush and reset behaviour are identical either way.

## Test plan
- Run with WIDTH=32 under both macro settings.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. done after E1, or after E33 with macro.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE.
- DIVU a=100, b=7 → lo=14, hi=2. busy high exactly 33 cycles; done after E33.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5.
- Flush at the 10th DIV cycle → busy=0 next cycle, hi/lo keep their prior values, no done. A second start issued mid-divide is ignored. A following MTHI a=0x1234 → hi=0x1234, done pulse, busy stays 0.
- Assert rst mid-divide → hi=lo=0, busy=0, done=0 the next cycle. A fresh DIVU 9/3 afterwards → lo=3, hi=0.
